// File: rtl/sw_target_sequencer.sv
// -----------------------------------------------------------------------------
// sw_target_sequencer
//   Target-side front end for the Smith-Waterman scoring array. One job:
//   accept start (latch the PE output select from query_len), stream the
//   target bases gap-free into the array, wait for the selected PE to report,
//   then hand the captured score downstream over a valid/ready port.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           job start pulse, honoured only while idle
//   query_len       query length in bases, sampled with an accepted start
//   t_valid/t_ready target base stream handshake
//   t_base, t_last  2-bit base (T=00 C=01 A=10 G=11), end-of-target marker
//   sm_en/sm_data   array enable and base data (one registered stage)
//   sm_sel          array output select (query_len-1, clamped)
//   sm_result/sm_vld array score and its valid flag
//   r_valid/r_ready result handshake
//   r_score, r_len  captured biased score, number of bases streamed
//   r_timeout       array never reported within LENGTH+TIMEOUT_SLACK cycles
//   r_underrun      target stream bubbled mid-sequence
//   busy            a job is in progress
// -----------------------------------------------------------------------------
module sw_target_sequencer #(
  parameter int SCORE_WIDTH   = 12,
  parameter int LENGTH        = 128,
  parameter int LOG_LENGTH    = $clog2(LENGTH) + 1,
  parameter int TLEN_WIDTH    = 16,
  parameter int TIMEOUT_SLACK = 16,
  parameter int MIN_GAP       = 2,
  parameter logic [SCORE_WIDTH-1:0] ZERO = {1'b1, {(SCORE_WIDTH-1){1'b0}}}
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LOG_LENGTH-1:0]  query_len,
  input  logic                   t_valid,
  output logic                   t_ready,
  input  logic [1:0]             t_base,
  input  logic                   t_last,
  output logic                   sm_en,
  output logic [1:0]             sm_data,
  output logic [LOG_LENGTH-1:0]  sm_sel,
  input  logic [SCORE_WIDTH-1:0] sm_result,
  input  logic                   sm_vld,
  output logic                   r_valid,
  input  logic                   r_ready,
  output logic [SCORE_WIDTH-1:0] r_score,
  output logic [TLEN_WIDTH-1:0]  r_len,
  output logic                   r_timeout,
  output logic                   r_underrun,
  output logic                   busy
);

  localparam int TO_LIMIT = LENGTH + TIMEOUT_SLACK;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam int GAP_W    = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT,
    S_OUT,
    S_GAP
  } state_t;

  state_t                 state_q;
  logic                   t_ready_q;
  logic                   sm_en_q;
  logic [1:0]             sm_data_q;
  logic [LOG_LENGTH-1:0]  sm_sel_q;
  logic                   r_valid_q;
  logic [SCORE_WIDTH-1:0] r_score_q;
  logic [TLEN_WIDTH-1:0]  r_len_q;
  logic                   r_timeout_q;
  logic                   r_underrun_q;
  logic                   seen_beat_q;
  logic [TO_W-1:0]        to_cnt_q;
  logic [GAP_W-1:0]       gap_cnt_q;

  logic [LOG_LENGTH-1:0]  sel_d;
  logic [TLEN_WIDTH-1:0]  len_d;

  // A zero or oversized query length selects the last PE of the array.
  always_comb begin
    sel_d = LOG_LENGTH'(LENGTH - 1);
    if (query_len != '0 && int'(query_len) <= LENGTH)
      sel_d = query_len - LOG_LENGTH'(1);
  end

  // Beat counter saturates rather than wrapping.
  always_comb begin
    len_d = r_len_q;
    if (!(&r_len_q))
      len_d = r_len_q + TLEN_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      t_ready_q    <= 1'b0;
      sm_en_q      <= 1'b0;
      sm_data_q    <= 2'b00;
      sm_sel_q     <= '0;
      r_valid_q    <= 1'b0;
      r_score_q    <= ZERO;
      r_len_q      <= '0;
      r_timeout_q  <= 1'b0;
      r_underrun_q <= 1'b0;
      seen_beat_q  <= 1'b0;
      to_cnt_q     <= '0;
      gap_cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          sm_en_q <= 1'b0;
          if (start) begin
            sm_sel_q     <= sel_d;
            r_len_q      <= '0;
            r_timeout_q  <= 1'b0;
            r_underrun_q <= 1'b0;
            seen_beat_q  <= 1'b0;
            t_ready_q    <= 1'b1;
            state_q      <= S_STREAM;
          end
        end

        S_STREAM: begin
          if (t_valid && t_ready_q) begin
            // Accepted beat drives the array during the following cycle.
            sm_en_q     <= 1'b1;
            sm_data_q   <= t_base;
            r_len_q     <= len_d;
            seen_beat_q <= 1'b1;
            if (t_last) begin
              t_ready_q <= 1'b0;
              to_cnt_q  <= '0;
              state_q   <= S_WAIT;
            end
          end else if (seen_beat_q) begin
            // The array needs a gap-free stream: a bubble ends the sequence.
            sm_en_q      <= 1'b0;
            r_underrun_q <= 1'b1;
            t_ready_q    <= 1'b0;
            to_cnt_q     <= '0;
            state_q      <= S_WAIT;
          end else begin
            sm_en_q <= 1'b0;
          end
        end

        S_WAIT: begin
          sm_en_q <= 1'b0;
          if (sm_vld) begin
            r_score_q <= sm_result;
            r_valid_q <= 1'b1;
            state_q   <= S_OUT;
          end else if (to_cnt_q == TO_W'(TO_LIMIT - 1)) begin
            // This edge is the TO_LIMIT-th waiting cycle.
            r_score_q   <= ZERO;
            r_timeout_q <= 1'b1;
            r_valid_q   <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end

        S_OUT: begin
          if (r_ready) begin
            r_valid_q <= 1'b0;
            gap_cnt_q <= '0;
            state_q   <= S_GAP;
          end
        end

        S_GAP: begin
          if (gap_cnt_q == GAP_W'(MIN_GAP - 1))
            state_q <= S_IDLE;
          else
            gap_cnt_q <= gap_cnt_q + GAP_W'(1);
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign t_ready    = t_ready_q;
  assign sm_en      = sm_en_q;
  assign sm_data    = sm_data_q;
  assign sm_sel     = sm_sel_q;
  assign r_valid    = r_valid_q;
  assign r_score    = r_score_q;
  assign r_len      = r_len_q;
  assign r_timeout  = r_timeout_q;
  assign r_underrun = r_underrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_sw_target_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sw_target_sequencer
//   Plays the role of the target DMA, the scoring array and the result sink.
//   Each job's expected select, stream, length, score and flags are derived
//   directly from the job description (bases, bubble point, array latency).
// -----------------------------------------------------------------------------
module tb_sw_target_sequencer;

  localparam int SW    = 12;
  localparam int L     = 128;
  localparam int LL    = 8;
  localparam int TW    = 16;
  localparam int SLACK = 16;
  localparam int MG    = 2;
  localparam logic [SW-1:0] ZERO = 12'h800;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LL-1:0] query_len = '0;
  logic          t_valid = 1'b0;
  logic          t_ready;
  logic [1:0]    t_base = 2'b00;
  logic          t_last = 1'b0;
  logic          sm_en;
  logic [1:0]    sm_data;
  logic [LL-1:0] sm_sel;
  logic [SW-1:0] sm_result = '0;
  logic          sm_vld = 1'b0;
  logic          r_valid;
  logic          r_ready = 1'b0;
  logic [SW-1:0] r_score;
  logic [TW-1:0] r_len;
  logic          r_timeout;
  logic          r_underrun;
  logic          busy;

  sw_target_sequencer #(
    .SCORE_WIDTH(SW), .LENGTH(L), .LOG_LENGTH(LL), .TLEN_WIDTH(TW),
    .TIMEOUT_SLACK(SLACK), .MIN_GAP(MG)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .query_len(query_len),
    .t_valid(t_valid), .t_ready(t_ready), .t_base(t_base), .t_last(t_last),
    .sm_en(sm_en), .sm_data(sm_data), .sm_sel(sm_sel),
    .sm_result(sm_result), .sm_vld(sm_vld),
    .r_valid(r_valid), .r_ready(r_ready), .r_score(r_score), .r_len(r_len),
    .r_timeout(r_timeout), .r_underrun(r_underrun), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // What the array sees: every enabled cycle's base and its cycle number.
  logic [1:0] en_data_q[$];
  int         en_cyc_q[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sm_en === 1'b1) begin
      en_data_q.push_back(sm_data);
      en_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_t_ready"}, 32'(t_ready), 0);
    chk({tag, "_sm_en"}, 32'(sm_en), 0);
    chk({tag, "_sm_data"}, 32'(sm_data), 0);
    chk({tag, "_sm_sel"}, 32'(sm_sel), 0);
    chk({tag, "_r_valid"}, 32'(r_valid), 0);
    chk({tag, "_r_score"}, 32'(r_score), 32'(ZERO));
    chk({tag, "_r_len"}, 32'(r_len), 0);
    chk({tag, "_r_timeout"}, 32'(r_timeout), 0);
    chk({tag, "_r_underrun"}, 32'(r_underrun), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  // One complete job. n = target length, k = beats delivered before a bubble
  // (k == n means no bubble), pre = idle cycles before the first beat,
  // vld_delay = array latency after WAIT entry (-1: array never reports),
  // hold = cycles r_ready is withheld (a stray start is pulsed meanwhile).
  task automatic run_job(input int qlen, input int n, input int k, input int pre,
                         input int vld_delay, input logic [SW-1:0] res,
                         input int hold, input bit use_fixed, input logic [63:0] fixed);
    logic [1:0]    bases[$];
    logic [SW-1:0] exp_score;
    int            exp_sel;
    int            waited;
    int            nseen;
    for (int i = 0; i < n; i++)
      bases.push_back(use_fixed ? fixed[2*i +: 2] : 2'($urandom_range(0, 3)));
    exp_sel = (qlen == 0 || qlen > L) ? L - 1 : qlen - 1;
    en_data_q.delete();
    en_cyc_q.delete();

    chk("idle_busy", 32'(busy), 0);
    chk("idle_t_ready", 32'(t_ready), 0);
    query_len = LL'(qlen);
    start = 1'b1;
    step();
    start = 1'b0;
    query_len = LL'($urandom);
    chk("sel_latch", 32'(sm_sel), 32'(exp_sel));
    chk("stream_busy", 32'(busy), 1);
    chk("len_cleared", 32'(r_len), 0);

    repeat (pre) begin
      t_valid = 1'b0;
      sm_vld = 1'($urandom_range(0, 1));
      sm_result = SW'($urandom);
      step();
    end
    chk("pre_sm_en", 32'(sm_en), 0);

    for (int i = 0; i < k; i++) begin
      chk("stream_t_ready", 32'(t_ready), 1);
      t_valid = 1'b1;
      t_base = bases[i];
      t_last = (k == n) && (i == n - 1);
      sm_vld = 1'($urandom_range(0, 1));
      sm_result = SW'($urandom);
      step();
    end
    t_last = 1'b0;
    if (k < n) begin
      t_valid = 1'b0;
      step();
      // Offer the rest of the target: it must not be taken.
      t_valid = 1'b1;
      t_base = bases[k];
    end else begin
      t_valid = 1'b0;
    end
    sm_vld = 1'b0;
    chk("wait_t_ready", 32'(t_ready), 0);

    if (vld_delay >= 0) begin
      repeat (vld_delay) step();
      chk("early_r_valid", 32'(r_valid), 0);
      sm_vld = 1'b1;
      sm_result = res;
      step();
      sm_vld = 1'b0;
      sm_result = SW'($urandom);
      exp_score = res;
    end else begin
      waited = 0;
      while (r_valid !== 1'b1 && waited < 400) begin
        step();
        waited++;
      end
      chk("timeout_cycles", 32'(waited), 32'(L + SLACK));
      exp_score = ZERO;
    end
    t_valid = 1'b0;

    chk("r_valid", 32'(r_valid), 1);
    chk("r_score", 32'(r_score), 32'(exp_score));
    chk("r_len", 32'(r_len), 32'(k));
    chk("r_timeout", 32'(r_timeout), 32'(vld_delay < 0));
    chk("r_underrun", 32'(r_underrun), 32'(k < n));

    nseen = en_data_q.size();
    chk("en_count", 32'(nseen), 32'(k));
    for (int i = 0; i < nseen && i < k; i++)
      chk("en_data", 32'(en_data_q[i]), 32'(bases[i]));
    if (nseen > 0)
      chk("en_contiguous", 32'(en_cyc_q[nseen-1] - en_cyc_q[0]), 32'(nseen - 1));

    for (int h = 0; h < hold; h++) begin
      r_ready = 1'b0;
      start = (h == 0);
      query_len = LL'($urandom);
      step();
      start = 1'b0;
      chk("hold_r_valid", 32'(r_valid), 1);
      chk("hold_r_score", 32'(r_score), 32'(exp_score));
      chk("hold_r_len", 32'(r_len), 32'(k));
      chk("hold_sm_sel", 32'(sm_sel), 32'(exp_sel));
    end

    r_ready = 1'b1;
    step();
    r_ready = 1'b0;
    chk("post_hs_r_valid", 32'(r_valid), 0);
    chk("gap_busy0", 32'(busy), 1);
    start = 1'b1;
    query_len = LL'($urandom);
    step();
    start = 1'b0;
    chk("gap_busy1", 32'(busy), 1);
    chk("gap_sm_en", 32'(sm_en), 0);
    step();
    chk("gap_done_busy", 32'(busy), 0);
    chk("gap_sm_sel", 32'(sm_sel), 32'(exp_sel));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    int vd;
    rst = 1'b1;
    step();
    step();
    chk_reset_vals("reset");
    rst = 1'b0;
    step();

    // A,C,G,T with t_last on T; array answers 0x80A.
    run_job(4, 4, 4, 0, 5, 12'h80A, 0, 1'b1, 64'h36);
    // Array never reports.
    run_job(8, 3, 3, 1, -1, 12'h000, 0, 1'b0, 64'h0);
    // Bubble after 2 of 5 bases.
    run_job(6, 5, 2, 0, 3, 12'h7F1, 0, 1'b0, 64'h0);
    // Downstream stalls 10 cycles with a stray start.
    run_job(10, 4, 4, 2, 0, 12'h123, 10, 1'b0, 64'h0);
    // Select clamping.
    run_job(0, 2, 2, 0, 1, 12'h9AB, 0, 1'b0, 64'h0);
    run_job(200, 2, 2, 0, 1, 12'h456, 0, 1'b0, 64'h0);
    run_job(128, 1, 1, 0, 2, 12'hFFF, 1, 1'b0, 64'h0);

    // Reset in the middle of streaming.
    query_len = 8'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      t_valid = 1'b1;
      t_base = 2'($urandom_range(0, 3));
      step();
    end
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    t_valid = 1'b0;
    step();
    step();
    chk("midrst_r_valid", 32'(r_valid), 0);
    rst = 1'b0;
    step();
    chk("postrst_r_valid", 32'(r_valid), 0);
    run_job(5, 3, 3, 0, 4, 12'h5A5, 0, 1'b0, 64'h0);

    // Randomized jobs.
    for (int j = 0; j < 24; j++) begin
      n = $urandom_range(1, 10);
      k = (n > 1 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : n;
      vd = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 30);
      run_job($urandom_range(0, 255), n, k, $urandom_range(0, 3), vd,
              SW'($urandom), $urandom_range(0, 4), 1'b0, 64'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
